// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: shares one MAC TX byte interface between two frame sources.
// Frames are arbitrated round-robin and the grant is held from SOP to EOP.
// After each frame an inter-frame gap is inserted. A length watchdog cuts off
// frames that run past MAX_FRAME_BYTES.
//
// Optional feature: define TX_ARB_STATS_EN to add the frame, abort and protocol
// error statistics counters (frames0_cnt, frames1_cnt, abort_cnt, proto_err_cnt).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant active, requests are sampled here only
// XFER  | granted source streams bytes to the MAC
// DRAIN | watchdog fired, swallow the granted source until its EOP
// GAP   | inter-frame gap countdown, then back to IDLE

module tx_frame_arbiter #(
    parameter int GAP_CYCLES      = 12,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int CNT_W           = 11,
    parameter int STAT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_req,
    input  logic [7:0]        s0_data,
    input  logic              s0_sop,
    input  logic              s0_eop,
    input  logic              s0_err,
    input  logic              s0_wren,
    output logic              s0_rdy,
    input  logic              s1_req,
    input  logic [7:0]        s1_data,
    input  logic              s1_sop,
    input  logic              s1_eop,
    input  logic              s1_err,
    input  logic              s1_wren,
    output logic              s1_rdy,
    output logic [7:0]        tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              tx_err,
    output logic              tx_wren,
    input  logic              tx_rdy,
    input  logic              tx_a_full,
    output logic              grant,
    output logic              busy,
    output logic              abort,
    output logic              proto_err
`ifdef TX_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] frames0_cnt,
    output logic [STAT_W-1:0] frames1_cnt,
    output logic [STAT_W-1:0] abort_cnt,
    output logic [STAT_W-1:0] proto_err_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // With no gap configured a finished frame goes straight back to IDLE.
    localparam logic [1:0] S_END = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FRAME_BYTES);

    // Reject parameter sets the counters cannot represent.
    if (CNT_W < $clog2(MAX_FRAME_BYTES + 1) || MAX_FRAME_BYTES < 1 || STAT_W < 1) begin : g_bad_params
        $error("tx_frame_arbiter: illegal parameterisation");
    end

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_sop_q, tx_sop_d;
    logic             tx_eop_q, tx_eop_d;
    logic             tx_err_q, tx_err_d;
    logic             tx_wren_q, tx_wren_d;
    logic             abort_q, abort_d;
    logic             proto_err_q, proto_err_d;

    logic [7:0]       sel_data;
    logic             sel_sop;
    logic             sel_eop;
    logic             sel_err;
    logic             sel_wren;
    logic             fwd_beat;
    logic [CNT_W-1:0] cnt_inc;

    // Route the granted source onto a common set of beat signals.
    always_comb begin
        sel_data = grant_q ? s1_data : s0_data;
        sel_sop  = grant_q ? s1_sop  : s0_sop;
        sel_eop  = grant_q ? s1_eop  : s0_eop;
        sel_err  = grant_q ? s1_err  : s0_err;
        sel_wren = grant_q ? s1_wren : s0_wren;
        // A beat is forwarded unless it is a first beat missing its SOP.
        fwd_beat = (state_q == S_XFER) && sel_wren && !(first_q && !sel_sop);
        // Saturating increment so a stuck counter can never wrap to zero.
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Source ready: XFER follows MAC back-pressure, DRAIN ignores the MAC.
    always_comb begin
        s0_rdy = 1'b0;
        s1_rdy = 1'b0;
        case (state_q)
            S_XFER: begin
                s0_rdy = !grant_q && tx_rdy && !tx_a_full;
                s1_rdy =  grant_q && tx_rdy && !tx_a_full;
            end
            S_DRAIN: begin
                s0_rdy = !grant_q;
                s1_rdy =  grant_q;
            end
            default: begin
                s0_rdy = 1'b0;
                s1_rdy = 1'b0;
            end
        endcase
    end

    // Arbitration FSM, frame watchdog and registered TX beat.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        tx_data_d   = tx_data_q;
        tx_sop_d    = tx_sop_q;
        tx_eop_d    = tx_eop_q;
        tx_err_d    = tx_err_q;
        tx_wren_d   = 1'b0;
        abort_d     = 1'b0;
        proto_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s0_req || s1_req) begin
                    // On a tie the port that did not win last time gets it.
                    grant_d = (s0_req && s1_req) ? ~last_q : s1_req;
                    state_d = S_XFER;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end

            S_XFER: begin
                if (sel_wren && first_q && !sel_sop) begin
                    // Drop the beat and keep waiting for a proper first beat.
                    proto_err_d = 1'b1;
                end else if (fwd_beat) begin
                    first_d   = 1'b0;
                    cnt_d     = cnt_inc;
                    tx_wren_d = 1'b1;
                    tx_data_d = sel_data;
                    tx_sop_d  = sel_sop;
                    tx_eop_d  = sel_eop;
                    tx_err_d  = sel_err;
                    if (sel_eop) begin
                        // EOP wins even on the beat that reaches the limit.
                        last_d  = grant_q;
                        state_d = S_END;
                        gap_d   = GAP_LOAD;
                    end else if (cnt_inc == MAX_CNT) begin
                        tx_eop_d = 1'b1;
                        tx_err_d = 1'b1;
                        abort_d  = 1'b1;
                        last_d   = grant_q;
                        state_d  = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (sel_wren && sel_eop) begin
                    state_d = S_END;
                    gap_d   = GAP_LOAD;
                end
            end

            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; last_q resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            gap_q       <= '0;
            tx_data_q   <= '0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_err_q    <= 1'b0;
            tx_wren_q   <= 1'b0;
            abort_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            tx_data_q   <= tx_data_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            tx_err_q    <= tx_err_d;
            tx_wren_q   <= tx_wren_d;
            abort_q     <= abort_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Markers are qualified with tx_wren so the MAC never sees stale flags.
    always_comb begin
        tx_data   = tx_data_q;
        tx_sop    = tx_sop_q && tx_wren_q;
        tx_eop    = tx_eop_q && tx_wren_q;
        tx_err    = tx_err_q && tx_wren_q;
        tx_wren   = tx_wren_q;
        grant     = grant_q;
        busy      = (state_q != S_IDLE);
        abort     = abort_q;
        proto_err = proto_err_q;
    end

`ifdef TX_ARB_STATS_EN
    logic [STAT_W-1:0] frames0_q, frames0_d;
    logic [STAT_W-1:0] frames1_q, frames1_d;
    logic [STAT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic [STAT_W-1:0] proto_cnt_q, proto_cnt_d;

    // Statistics: completed frames per port, aborts and protocol errors.
    always_comb begin
        frames0_d   = frames0_q;
        frames1_d   = frames1_q;
        abort_cnt_d = abort_cnt_q;
        proto_cnt_d = proto_cnt_q;
        if (fwd_beat && sel_eop && !grant_q) frames0_d = frames0_q + 1'b1;
        if (fwd_beat && sel_eop &&  grant_q) frames1_d = frames1_q + 1'b1;
        if (abort_d)                         abort_cnt_d = abort_cnt_q + 1'b1;
        if (proto_err_d)                     proto_cnt_d = proto_cnt_q + 1'b1;
    end

    // Statistics registers, free-running modulo 2^STAT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames0_q   <= '0;
            frames1_q   <= '0;
            abort_cnt_q <= '0;
            proto_cnt_q <= '0;
        end else begin
            frames0_q   <= frames0_d;
            frames1_q   <= frames1_d;
            abort_cnt_q <= abort_cnt_d;
            proto_cnt_q <= proto_cnt_d;
        end
    end

    assign frames0_cnt   = frames0_q;
    assign frames1_cnt   = frames1_q;
    assign abort_cnt     = abort_cnt_q;
    assign proto_err_cnt = proto_cnt_q;
`endif

endmodule
